// File: rtl/tank_pump_ctrl_pkg.sv
// Shared types and helpers for the multi-pump sump controller.
package tank_pump_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BOOST = 2'd2,
        FAULT = 2'd3
    } pumpState_t;

    // Width of the lead-pump index; a single pump still gets one bit.
    function automatic int leadWidth(input int nPumps);
        return (nPumps > 1) ? $clog2(nPumps) : 1;
    endfunction

endpackage

// File: rtl/tank_pump_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != MAX_CNT)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tank_pump_ctrl.sv
// Sump pump controller: round-robin lead pump, escalation to all pumps on a
// sustained high level, sticky fault on an inconsistent sensor pair.
module tank_pump_ctrl
    import tank_pump_ctrl_pkg::*;
#(
    parameter  int N_PUMPS       = 2,
    parameter  int MIN_ON_CYCLES = 4,
    parameter  int BOOST_CYCLES  = 8,
    localparam int LEAD_W        = leadWidth(N_PUMPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sensor_lo,
    input  logic               sensor_hi,
    output logic [N_PUMPS-1:0] pump,
    output logic [LEAD_W-1:0]  lead,
    output logic               fault,
    output logic [1:0]         dbgState
);

    localparam int ON_W = $clog2(MIN_ON_CYCLES + 1);
    localparam int HI_W = (BOOST_CYCLES > 1) ? $clog2(BOOST_CYCLES) : 1;

    pumpState_t        state;
    pumpState_t        nextState;
    logic [LEAD_W-1:0] leadReg;
    logic [LEAD_W-1:0] leadNext;
    logic [ON_W-1:0]   onCnt;
    logic [HI_W-1:0]   hiCnt;
    logic [N_PUMPS-1:0] pumpNext;
    logic              pumping;
    logic              inconsistent;
    logic              exitOk;
    logic              boostHit;
    logic              advanceLead;

    assign pumping      = (state == RUN) || (state == BOOST);
    assign inconsistent = sensor_hi && !sensor_lo;
    assign exitOk       = !sensor_lo && (onCnt == ON_W'(MIN_ON_CYCLES));
    assign boostHit     = sensor_hi && (hiCnt == HI_W'(BOOST_CYCLES - 1));
    assign leadNext     = (leadReg == LEAD_W'(N_PUMPS - 1)) ? '0 : leadReg + LEAD_W'(1);
    assign dbgState     = state;

    // on_cnt runs only while pumping, so it reads 0 on the first RUN cycle.
    sat_counter #(.WIDTH(ON_W), .MAX_VAL(MIN_ON_CYCLES)) onCounter (
        .clk   (clk),
        .reset (reset),
        .clear (!pumping),
        .inc   (1'b1),
        .count (onCnt)
    );

    sat_counter #(.WIDTH(HI_W), .MAX_VAL(BOOST_CYCLES - 1)) hiCounter (
        .clk   (clk),
        .reset (reset),
        .clear ((state != RUN) || !sensor_hi),
        .inc   (1'b1),
        .count (hiCnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            leadReg <= '0;
        end else begin
            state <= nextState;
            if (advanceLead) begin
                leadReg <= leadNext;
            end
        end
    end

    always_comb begin
        nextState   = state;
        advanceLead = 1'b0;
        pumpNext    = '0;
        case (state)
            IDLE: begin
                if (inconsistent)   nextState = FAULT;
                else if (sensor_hi) nextState = RUN;
            end
            RUN: begin
                pumpNext = N_PUMPS'(1) << leadReg;
                if (inconsistent)  nextState = FAULT;
                else if (exitOk)   nextState = IDLE;
                else if (boostHit) nextState = BOOST;
            end
            BOOST: begin
                pumpNext = '1;
                if (inconsistent) nextState = FAULT;
                else if (exitOk)  nextState = IDLE;
            end
            default: nextState = FAULT;
        endcase
        if (pumping && (nextState == IDLE)) begin
            advanceLead = 1'b1;
        end
    end

    // Output register: outputs trail the state register by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pump  <= '0;
            lead  <= '0;
            fault <= 1'b0;
        end else begin
            pump  <= pumpNext;
            lead  <= leadReg;
            fault <= (state == FAULT);
        end
    end

endmodule

// File: tb/tb_tank_pump_ctrl.sv
// Bench for tank_pump_ctrl: three configurations share one sensor stream and
// are checked every cycle against an episode-level model of the pump rules.
module tb_tank_pump_ctrl;

    logic clk;
    logic reset;
    logic sensorLo;
    logic sensorHi;

    logic [1:0] pumpA;
    logic       leadA;
    logic       faultA;
    logic [1:0] stA;
    logic [2:0] pumpB;
    logic [1:0] leadB;
    logic       faultB;
    logic [1:0] stB;
    logic       pumpC;
    logic       leadC;
    logic       faultC;
    logic [1:0] stC;

    int nChecks = 0;
    int nFails  = 0;

    // configuration table: A = (2,4,8), B = (3,4,8), C = (1,3,1)
    int cfgPumps[3] = '{2, 3, 1};
    int cfgMinOn[3] = '{4, 4, 3};
    int cfgBoost[3] = '{8, 8, 1};

    tank_pump_ctrl #(.N_PUMPS(2), .MIN_ON_CYCLES(4), .BOOST_CYCLES(8)) dutA (
        .clk(clk), .reset(reset), .sensor_lo(sensorLo), .sensor_hi(sensorHi),
        .pump(pumpA), .lead(leadA), .fault(faultA), .dbgState(stA)
    );
    tank_pump_ctrl #(.N_PUMPS(3), .MIN_ON_CYCLES(4), .BOOST_CYCLES(8)) dutB (
        .clk(clk), .reset(reset), .sensor_lo(sensorLo), .sensor_hi(sensorHi),
        .pump(pumpB), .lead(leadB), .fault(faultB), .dbgState(stB)
    );
    tank_pump_ctrl #(.N_PUMPS(1), .MIN_ON_CYCLES(3), .BOOST_CYCLES(1)) dutC (
        .clk(clk), .reset(reset), .sensor_lo(sensorLo), .sensor_hi(sensorHi),
        .pump(pumpC), .lead(leadC), .fault(faultC), .dbgState(stC)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model: mode 0 dry, 1 single pump, 2 all pumps, 3 faulted
    int         mMode[3];
    int         mAge[3];
    int         mStreak[3];
    int         mLead[3];
    logic [2:0] expPump[3];
    logic [1:0] expLead[3];
    logic       expFault[3];
    bit         modelValid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                mMode[i] = 0; mAge[i] = 0; mStreak[i] = 0; mLead[i] = 0;
                expPump[i] = 3'd0; expLead[i] = 2'd0; expFault[i] = 1'b0;
            end else begin
                expPump[i]  = (mMode[i] == 1) ? 3'(1 << mLead[i]) :
                              (mMode[i] == 2) ? 3'((1 << cfgPumps[i]) - 1) : 3'd0;
                expLead[i]  = 2'(mLead[i]);
                expFault[i] = (mMode[i] == 3);
                if (mMode[i] == 3) begin
                    mMode[i] = 3;
                end else if (sensorHi && !sensorLo) begin
                    mMode[i] = 3;
                end else if (mMode[i] == 0) begin
                    if (sensorHi) begin
                        mMode[i] = 1; mAge[i] = 0; mStreak[i] = 0;
                    end
                end else if (!sensorLo && mAge[i] >= cfgMinOn[i]) begin
                    mMode[i] = 0;
                    mLead[i] = (mLead[i] + 1) % cfgPumps[i];
                end else begin
                    if (mMode[i] == 1 && sensorHi && mStreak[i] + 1 >= cfgBoost[i]) mMode[i] = 2;
                    mAge[i]++;
                    mStreak[i] = sensorHi ? mStreak[i] + 1 : 0;
                end
            end
        end
        if (reset) modelValid = 1'b1;
    end

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every cycle, every output of every configuration
    always @(negedge clk) begin
        if (modelValid) begin
            check("pumpA",  3'(pumpA),  expPump[0]);
            check("leadA",  3'(leadA),  3'(expLead[0]));
            check("faultA", 3'(faultA), 3'(expFault[0]));
            check("pumpB",  3'(pumpB),  expPump[1]);
            check("leadB",  3'(leadB),  3'(expLead[1]));
            check("faultB", 3'(faultB), 3'(expFault[1]));
            check("pumpC",  3'(pumpC),  expPump[2]);
            check("leadC",  3'(leadC),  3'(expLead[2]));
            check("faultC", 3'(faultC), 3'(expFault[2]));
        end
    end

    // driver: set sensors, then hold them for n falling edges
    task automatic drive(input logic lo, input logic hi, input int n);
        sensorLo = lo;
        sensorHi = hi;
        repeat (n) @(negedge clk);
    endtask

    task automatic countOn(output int cnt);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pumpA == 2'b00) break;
            cnt++;
        end
    endtask

    int onCycles;
    int r;
    int len;

    initial begin
        reset = 1'b1; sensorLo = 1'b0; sensorHi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("lit_reset_pump",  3'(pumpA), 3'd0);
        check("lit_reset_lead",  3'(leadA), 3'd0);
        check("lit_reset_fault", 3'(faultA), 3'd0);

        // first episode: lead 0, five cycles on, lead advances to 1
        drive(1'b1, 1'b1, 2);
        check("lit_ep1_pump", 3'(pumpA), 3'b001);
        sensorLo = 1'b0; sensorHi = 1'b0;
        countOn(onCycles);
        check("lit_ep1_len", 3'(onCycles + 1), 3'd5);
        check("lit_ep1_lead", 3'(leadA), 3'd1);

        // second episode uses pump 1 and wraps lead back to 0
        drive(1'b1, 1'b1, 2);
        check("lit_ep2_pump", 3'(pumpA), 3'b010);
        drive(1'b0, 1'b0, 6);
        check("lit_ep2_off", 3'(pumpA), 3'd0);
        check("lit_ep2_lead", 3'(leadA), 3'd0);

        // boost after the 8th consecutive high sample
        drive(1'b1, 1'b1, 9);
        check("lit_pre_boost", 3'(pumpA), 3'b001);
        drive(1'b1, 1'b1, 1);
        check("lit_boost", 3'(pumpA), 3'b011);
        check("lit_boost_c", 3'(pumpC), 3'b001);
        drive(1'b0, 1'b0, 2);
        check("lit_boost_off", 3'(pumpA), 3'd0);
        check("lit_boost_lead", 3'(leadA), 3'd1);

        // fault is sticky with lead frozen until reset
        drive(1'b1, 1'b1, 3);
        check("lit_run_lead1", 3'(pumpA), 3'b010);
        drive(1'b0, 1'b1, 2);
        check("lit_fault_pump", 3'(pumpA), 3'd0);
        check("lit_fault_flag", 3'(faultA), 3'd1);
        drive(1'b1, 1'b0, 4);
        check("lit_fault_stuck", 3'(faultA), 3'd1);
        check("lit_fault_lead", 3'(leadA), 3'd1);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1);
        reset = 1'b0;
        check("lit_clr_fault", 3'(faultA), 3'd0);
        check("lit_clr_lead", 3'(leadA), 3'd0);

        // hysteresis band keeps pumps off; short high still gets minimum on-time
        drive(1'b1, 1'b0, 5);
        check("lit_hyst", 3'(pumpA), 3'd0);
        drive(1'b1, 1'b1, 1);
        sensorLo = 1'b0; sensorHi = 1'b0;
        countOn(onCycles);
        check("lit_min_on", 3'(onCycles), 3'd5);

        // reset in the middle of a three-pump boost
        drive(1'b1, 1'b1, 11);
        check("lit_boost3", pumpB, 3'b111);
        check("lit_boost3_lead", 3'(leadB), 3'd1);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1);
        reset = 1'b0;
        check("lit_rst3_pump", pumpB, 3'd0);
        check("lit_rst3_lead", 3'(leadB), 3'd0);
        drive(1'b1, 1'b0, 4);
        check("lit_rst3_idle", pumpB, 3'd0);

        // randomized phase
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            len = $urandom_range(1, 14);
            if (r < 5) begin
                reset = 1'b1;
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 2));
                reset = 1'b0;
            end else if (r < 8) begin
                drive(1'b0, 1'b1, $urandom_range(1, 3));
            end else if (r < 40) begin
                drive(1'b0, 1'b0, len);
            end else if (r < 65) begin
                drive(1'b1, 1'b0, len);
            end else begin
                drive(1'b1, 1'b1, len);
            end
        end

        drive(1'b0, 1'b0, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
